// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line, consumer acknowledge and receive status of the UART receiver
interface uart_rx_if #(
   parameter int data_bits = 8
);
   logic rxd;
   logic rdrf_clr;
   logic [data_bits-1:0] RDR;
   logic rdrf;
   logic framing_err;
   logic overrun_err;
   modport master(output rxd, rdrf_clr, input RDR, rdrf, framing_err, overrun_err);
   modport slave(input rxd, rdrf_clr, output RDR, rdrf, framing_err, overrun_err);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8x oversampling UART receiver with input synchronizer, sticky framing/overrun flags
module uart_rx #(
   parameter int data_bits = 8,
   parameter int clks_per_tick = 13
) (
   input logic sysclk,
   input logic rst,
   uart_rx_if.slave bus
);
   localparam int tw = $clog2(clks_per_tick);
   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] START = 3'd1;
   localparam logic [2:0] DATA = 3'd2;
   localparam logic [2:0] STOP = 3'd3;
   localparam logic [2:0] BRK = 3'd4;
   logic s1;
   logic rxs;
   logic [tw-1:0] tc;
   logic tick;
   logic [2:0] state;
   logic [2:0] ct;
   logic [3:0] bct;
   logic [data_bits-1:0] rsr;
   logic done;
   logic load;
   assign tick = tc == tw'(clks_per_tick - 1);
   assign done = tick && state == STOP && ct == 3'd7;
   // a pending acknowledge frees RDR for the frame completing in the same cycle
   assign load = done && (!bus.rdrf || bus.rdrf_clr);
   always_ff @(posedge sysclk or posedge rst)
      if (rst) begin
         s1 <= 1'b1;
         rxs <= 1'b1;
         tc <= '0;
      end else begin
         s1 <= bus.rxd;
         rxs <= s1;
         tc <= tick ? '0 : tc + 1'b1;
      end
   always_ff @(posedge sysclk or posedge rst)
      if (rst) begin
         state <= IDLE;
         ct <= '0;
         bct <= '0;
         rsr <= '0;
      end else if (tick)
         case (state)
            IDLE:
               if (!rxs) begin
                  ct <= '0;
                  state <= START;
               end
            START:
               if (ct == 3'd3) begin
                  ct <= '0;
                  bct <= '0;
                  state <= rxs ? IDLE : DATA;
               end else
                  ct <= ct + 1'b1;
            DATA: begin
               ct <= ct + 1'b1;
               if (ct == 3'd7) begin
                  rsr <= {rxs, rsr[data_bits-1:1]};
                  bct <= bct + 1'b1;
                  if (bct == 4'(data_bits - 1)) state <= STOP;
               end
            end
            STOP: begin
               ct <= ct + 1'b1;
               if (ct == 3'd7) state <= rxs ? IDLE : BRK;
            end
            BRK:
               if (rxs) state <= IDLE;
            default:
               state <= IDLE;
         endcase
   always_ff @(posedge sysclk or posedge rst)
      if (rst) begin
         bus.RDR <= '0;
         bus.rdrf <= 1'b0;
         bus.framing_err <= 1'b0;
         bus.overrun_err <= 1'b0;
      end else begin
         if (load) bus.RDR <= rsr;
         bus.rdrf <= done || (bus.rdrf && !bus.rdrf_clr);
         bus.framing_err <= (done && !rxs) || (bus.framing_err && !bus.rdrf_clr);
         bus.overrun_err <= (done && bus.rdrf && !bus.rdrf_clr) || (bus.overrun_err && !bus.rdrf_clr);
      end
endmodule
